// File: rtl/immed_gen.sv
// RV32I immediate generator: extracts and sign-extends the instruction
// immediate selected by the class in cword[3:0], plus a registered copy.
module immed_gen (
   input  logic        clk,
   input  logic        rst,
   input  logic [22:0] cword,
   input  logic [31:0] inst,
   output logic [31:0] imm,
   output logic        illegal,
   output logic [31:0] imm_q,
   output logic        illegal_q
);

   typedef enum logic [3:0] {
      T_LOAD  = 4'd0,
      T_ALUI  = 4'd1,
      T_STORE = 4'd2,
      T_REG   = 4'd3,
      T_LUI   = 4'd4,
      T_AUIPC = 4'd5,
      T_BRANCH= 4'd6,
      T_JALR  = 4'd7,
      T_JAL   = 4'd8
   } inst_type_t;

   logic [3:0] instType;
   assign instType = cword[3:0];

   // The format comes from instType alone; opcode bits are never consulted.
   always_comb begin
      imm     = 32'h0000_0000;
      illegal = 1'b0;
      case (instType)
         T_LOAD, T_ALUI, T_JALR:
            imm = {{20{inst[31]}}, inst[31:20]};
         T_STORE:
            imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         T_BRANCH:
            imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         T_JAL:
            imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         T_LUI, T_AUIPC:
            imm = {inst[31:12], 12'h000};
         T_REG:
            imm = 32'h0000_0000;
         default: begin
            imm     = 32'h0000_0000;
            illegal = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         imm_q     <= 32'h0000_0000;
         illegal_q <= 1'b0;
      end else begin
         imm_q     <= imm;
         illegal_q <= illegal;
      end
   end

endmodule

// File: tb/tb_immed_gen.sv
// Directed self-checking bench for immed_gen: every format, don't-care
// control bits, illegal types, and the registered path with async reset.
module tb_immed_gen;

   logic        clk;
   logic        rst;
   logic [22:0] cword;
   logic [31:0] inst;
   logic [31:0] imm;
   logic        illegal;
   logic [31:0] imm_q;
   logic        illegal_q;

   int testsRun;
   int testsFailed;

   immed_gen dut (
      .clk       (clk),
      .rst       (rst),
      .cword     (cword),
      .inst      (inst),
      .imm       (imm),
      .illegal   (illegal),
      .imm_q     (imm_q),
      .illegal_q (illegal_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Upper control bits are randomized so they are exercised as don't-cares.
   task automatic applyStimulus(input logic [3:0] instType, input logic [31:0] word);
      logic [18:0] junk;
      junk  = 19'($urandom);
      cword = {junk, instType};
      inst  = word;
      #1;
   endtask

   typedef struct {
      string       name;
      logic [3:0]  instType;
      logic [31:0] word;
      logic [31:0] expImm;
   } vec_t;

   vec_t vecs[$];

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      rst   = 1'b0;
      cword = '0;
      inst  = '0;

      vecs.push_back('{"lui",      4'd4, 32'h030391b7, 32'h03039000});
      vecs.push_back('{"auipc",    4'd5, 32'h030391b7, 32'h03039000});
      vecs.push_back('{"jal",      4'd8, 32'h038031ef, 32'd12344});
      vecs.push_back('{"beq+128",  4'd6, 32'h08418063, 32'd128});
      vecs.push_back('{"beq-4",    4'd6, 32'hfe000ee3, 32'hFFFFFFFC});
      vecs.push_back('{"sb",       4'd2, 32'h08320023, 32'd128});
      vecs.push_back('{"lb",       4'd0, 32'h08020183, 32'd128});
      vecs.push_back('{"addi123",  4'd1, 32'h07b20193, 32'd123});
      vecs.push_back('{"addi-1",   4'd1, 32'hfff00093, 32'hFFFFFFFF});
      vecs.push_back('{"jalr-1",   4'd7, 32'hfff00093, 32'hFFFFFFFF});
      vecs.push_back('{"add",      4'd3, 32'h005201b3, 32'h00000000});
      vecs.push_back('{"jal-neg",  4'd8, 32'h80000000, 32'hFFF00000});

      // Async reset between edges, before any clock has captured anything
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_imm_q", imm_q, 32'h0);
      checkOutput("rst_illegal_q", {31'b0, illegal_q}, 32'h0);
      @(posedge clk); #1;
      checkOutput("rst_hold_imm_q", imm_q, 32'h0);

      // Combinational path, each vector twice with different junk control bits
      foreach (vecs[i]) begin
         for (int r = 0; r < 2; r++) begin
            applyStimulus(vecs[i].instType, vecs[i].word);
            checkOutput({vecs[i].name, "_imm"}, imm, vecs[i].expImm);
            checkOutput({vecs[i].name, "_illegal"}, {31'b0, illegal}, 32'h0);
         end
      end

      for (int t = 9; t < 16; t++) begin
         applyStimulus(4'(t), $urandom);
         checkOutput($sformatf("type%0d_imm", t), imm, 32'h0);
         checkOutput($sformatf("type%0d_illegal", t), {31'b0, illegal}, 32'h1);
      end
      checkOutput("rst_hold_during_comb", imm_q, 32'h0);

      // Registered path
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(4'd4, 32'h030391b7);
      @(posedge clk); #1;
      checkOutput("lui_imm_q", imm_q, 32'h03039000);
      checkOutput("lui_illegal_q", {31'b0, illegal_q}, 32'h0);

      applyStimulus(4'd3, 32'h005201b3);
      checkOutput("add_imm_now", imm, 32'h0);
      checkOutput("add_imm_q_held", imm_q, 32'h03039000);
      @(posedge clk); #1;
      checkOutput("add_imm_q", imm_q, 32'h0);

      applyStimulus(4'd12, 32'hdeadbeef);
      checkOutput("illegal12_imm", imm, 32'h0);
      checkOutput("illegal12_flag", {31'b0, illegal}, 32'h1);
      @(posedge clk); #1;
      checkOutput("illegal12_illegal_q", {31'b0, illegal_q}, 32'h1);

      applyStimulus(4'd1, 32'hfff00093);
      @(posedge clk); #1;
      checkOutput("addi_imm_q", imm_q, 32'hFFFFFFFF);
      checkOutput("addi_illegal_q", {31'b0, illegal_q}, 32'h0);

      applyStimulus(4'd13, 32'h12345678);
      @(posedge clk); #1;
      checkOutput("pre_rst_illegal_q", {31'b0, illegal_q}, 32'h1);
      applyStimulus(4'd6, 32'hfe000ee3);
      @(posedge clk); #1;
      checkOutput("pre_rst_imm_q", imm_q, 32'hFFFFFFFC);

      // Mid-stream reset between edges clears immediately
      @(negedge clk);
      applyStimulus(4'd9, 32'h0);
      rst = 1'b1;
      #1;
      checkOutput("midrst_imm_q", imm_q, 32'h0);
      checkOutput("midrst_illegal_q", {31'b0, illegal_q}, 32'h0);
      checkOutput("midrst_comb_illegal", {31'b0, illegal}, 32'h1);
      @(posedge clk); #1;
      checkOutput("midrst_hold_illegal_q", {31'b0, illegal_q}, 32'h0);

      @(negedge clk);
      rst = 1'b0;
      applyStimulus(4'd2, 32'h08320023);
      @(posedge clk); #1;
      checkOutput("post_rst_imm_q", imm_q, 32'd128);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
